// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a one-cycle-latency FIFO into a 3-entry queue and streams it out in BURST-beat frames
module fifo_burst_reader #(
  parameter int WIDTH = 16,
  parameter int BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_valid,
  output logic             fifo_flush,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [15:0]      beat_cnt,
  output logic             err
);
  logic [WIDTH-1:0] q [3];
  logic [1:0] wr_ptr, rd_ptr, occ;
  logic inflight, rst_d, wr, xfer, last_beat;
  assign fifo_flush = flush;
  // a pop is only issued when the queue has room for it and every pop still in flight
  assign fifo_pop = !rst && !flush && !fifo_empty && ({1'b0, occ} + {2'b0, inflight} < 3'd3);
  assign out_valid = occ != 2'd0;
  assign out_data = q[rd_ptr];
  assign last_beat = beat_cnt == 16'(BURST - 1);
  assign out_last = out_valid && last_beat;
  assign xfer = out_valid && out_ready;
  assign wr = fifo_valid && inflight && !flush;
  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      q <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
      err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= fifo_pop;
      if (wr) begin
        q[wr_ptr] <= fifo_rdata;
        wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
        beat_cnt <= last_beat ? '0 : beat_cnt + 16'd1;
      end
      occ <= occ + {1'b0, wr} - {1'b0, xfer};
      if (fifo_valid && !inflight && !rst_d) err <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (!rst && wr) assert (occ != 2'd3);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed table plus corner-case sequences against a one-cycle-latency FIFO model
module tb_fifo_burst_reader;
  localparam int W = 16, B = 8;
  logic clk = 0, rst = 1, fifo_empty = 1, fifo_pop, fifo_valid = 0, fifo_flush, flush = 0;
  logic [W-1:0] fifo_rdata = '0, out_data;
  logic out_valid, out_ready = 0, out_last, err;
  logic [15:0] beat_cnt;
  int compared = 0, mismatched = 0, pops = 0, tb_beat = 0;
  logic pend = 0, force_empty = 0, sb_on = 0;
  logic [W-1:0] pend_d = '0;
  logic [W-1:0] mq[$], exp_q[$];
  typedef struct { logic rdy, pop, valid; logic [W-1:0] data; logic last; logic [15:0] beat; } vec_t;
  vec_t tv [19];
  always #5 clk = ~clk;
  fifo_burst_reader #(.WIDTH(W), .BURST(B)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata),
    .fifo_valid(fifo_valid), .fifo_flush(fifo_flush), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .beat_cnt(beat_cnt), .err(err)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic drive();
    @(negedge clk);
    fifo_valid = pend;
    fifo_rdata = pend_d;
    fifo_empty = force_empty || mq.size() == 0;
    #1;
  endtask
  task automatic fin();
    chk("pop_when_empty", {31'b0, fifo_pop && fifo_empty}, 0);
    if (sb_on && out_valid && out_ready) begin
      chk("sb_occupancy", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        chk("sb_data", out_data, exp_q.pop_front());
        chk("sb_last", out_last, tb_beat == B - 1);
        chk("sb_beat", beat_cnt, tb_beat);
        tb_beat = (tb_beat + 1) % B;
      end
    end
    if (fifo_flush) mq.delete();
    pops += fifo_pop;
    pend = fifo_pop;
    if (fifo_pop && mq.size() > 0) pend_d = mq.pop_front();
    @(posedge clk);
    #1;
  endtask
  task automatic cycle();
    drive();
    fin();
  endtask
  task automatic do_reset();
    rst = 1; flush = 0; out_ready = 0; force_empty = 0; sb_on = 0;
    mq.delete(); exp_q.delete();
    cycle();
    drive();
    chk("rst_pop", fifo_pop, 0);
    chk("rst_flush", fifo_flush, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_err", err, 0);
    fin();
    rst = 0; pops = 0; tb_beat = 0;
  endtask
  task automatic drain(input string n, input int bound);
    int c = 0;
    while (exp_q.size() > 0 && c < bound) begin
      cycle();
      c++;
    end
    chk(n, exp_q.size(), 0);
  endtask
  initial begin
    int gap, n;
    logic [W-1:0] v;
    tv = '{
      '{1, 1, 0, 16'd0,  0, 16'd0}, '{1, 1, 0, 16'd0,  0, 16'd0}, '{1, 1, 1, 16'd1,  0, 16'd0},
      '{1, 1, 1, 16'd2,  0, 16'd1}, '{1, 1, 1, 16'd3,  0, 16'd2}, '{1, 1, 1, 16'd4,  0, 16'd3},
      '{1, 1, 1, 16'd5,  0, 16'd4}, '{1, 1, 1, 16'd6,  0, 16'd5}, '{1, 1, 1, 16'd7,  0, 16'd6},
      '{1, 1, 1, 16'd8,  1, 16'd7}, '{1, 1, 1, 16'd9,  0, 16'd0}, '{1, 1, 1, 16'd10, 0, 16'd1},
      '{1, 1, 1, 16'd11, 0, 16'd2}, '{1, 1, 1, 16'd12, 0, 16'd3}, '{1, 1, 1, 16'd13, 0, 16'd4},
      '{1, 1, 1, 16'd14, 0, 16'd5}, '{1, 0, 1, 16'd15, 0, 16'd6}, '{1, 0, 1, 16'd16, 1, 16'd7},
      '{1, 0, 0, 16'd0,  0, 16'd0}
    };
    do_reset();
    for (int i = 1; i <= 16; i++) mq.push_back(W'(i));
    for (int i = 0; i < 19; i++) begin
      out_ready = tv[i].rdy;
      drive();
      chk($sformatf("t%0d_pop", i), fifo_pop, tv[i].pop);
      chk($sformatf("t%0d_valid", i), out_valid, tv[i].valid);
      chk($sformatf("t%0d_beat", i), beat_cnt, tv[i].beat);
      if (tv[i].valid) begin
        chk($sformatf("t%0d_data", i), out_data, tv[i].data);
        chk($sformatf("t%0d_last", i), out_last, tv[i].last);
      end
      fin();
    end
    chk("stream_pops", pops, 16);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mq.push_back(16'h100 + W'(i));
      exp_q.push_back(16'h100 + W'(i));
    end
    for (int i = 0; i < 10; i++) begin
      drive();
      if (i >= 2) begin
        chk("bp_stable_data", out_data, 16'h100);
        chk("bp_stable_beat", beat_cnt, 0);
        chk("bp_stable_last", out_last, 0);
      end
      fin();
    end
    chk("bp_pops", pops, 3);
    drive();
    chk("bp_valid", out_valid, 1);
    chk("bp_hold_pop", fifo_pop, 0);
    fin();
    out_ready = 1; sb_on = 1; gap = 0; n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      drive();
      if (!out_valid) gap++;
      fin();
      n++;
    end
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_gap", gap, 0);
    chk("bp_cycles", n, 16);
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      v = W'($urandom);
      mq.push_back(v);
      exp_q.push_back(v);
    end
    sb_on = 1; n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    chk("rnd_drain", exp_q.size(), 0);
    drive();
    chk("rnd_err", err, 0);
    fin();
    do_reset();
    for (int i = 0; i < 20; i++) mq.push_back(16'h200 + W'(i));
    out_ready = 1;
    for (int i = 0; i < 7; i++) cycle();
    flush = 1;
    drive();
    chk("fl_flush", fifo_flush, 1);
    chk("fl_pop", fifo_pop, 0);
    chk("fl_beat_before", beat_cnt, 5);
    chk("fl_data_before", out_data, 16'h205);
    fin();
    flush = 0;
    drive();
    chk("fl_valid_after", out_valid, 0);
    chk("fl_beat_after", beat_cnt, 0);
    chk("fl_err_after", err, 0);
    chk("fl_fifo_flush_after", fifo_flush, 0);
    fin();
    for (int i = 0; i < 10; i++) begin
      mq.push_back(16'h300 + W'(i));
      exp_q.push_back(16'h300 + W'(i));
    end
    sb_on = 1; tb_beat = 0;
    drain("fl_refill_drain", 40);
    do_reset();
    pend = 1; pend_d = 16'hdead;
    cycle();
    drive();
    chk("sp_post_rst_err", err, 0);
    chk("sp_post_rst_valid", out_valid, 0);
    fin();
    cycle();
    pend = 1; pend_d = 16'hbeef;
    drive();
    chk("sp_err_same_cycle", err, 0);
    fin();
    drive();
    chk("sp_err_set", err, 1);
    chk("sp_no_data", out_valid, 0);
    fin();
    flush = 1;
    cycle();
    flush = 0;
    drive();
    chk("sp_err_through_flush", err, 1);
    fin();
    repeat (3) cycle();
    drive();
    chk("sp_err_sticky", err, 1);
    fin();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      mq.push_back(16'h400 + W'(i));
      exp_q.push_back(16'h400 + W'(i));
    end
    sb_on = 1; out_ready = 1; n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      force_empty = (n % 2) == 1;
      cycle();
      n++;
    end
    force_empty = 0;
    chk("tog_drain", exp_q.size(), 0);
    chk("tog_pops", pops, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain engine for the sample FIFOs in the FIR accelerator. It issues pops to a FIFO whose read data returns one cycle after the pop, and buffers the returned samples in a 3-entry internal queue. It presents them downstream on a valid/ready stream, tagging every BURST-th accepted sample with a last flag so the FIR datapath can frame coefficient windows. It sits between a sample FIFO's pop/rdata/valid/empty/flush port and the filter core input.

## Interface
- WIDTH, 16, sample width in bits
- BURST, 8, samples per burst; legal range 2..65535

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO has no entries
- fifo_pop  out  1  pop request to FIFO
- fifo_rdata  in  WIDTH  FIFO read data; meaningful when fifo_valid
- fifo_valid  in  1  read data returned; must be high exactly one cycle after each accepted pop
- fifo_flush  out  1  flush forwarded to FIFO (equals flush)
- flush  in  1  synchronous clear of reader and FIFO
- out_data  out  WIDTH  head sample
- out_valid  out  1  head sample present
- out_ready  in  1  downstream accepts; transfer = out_valid & out_ready
- out_last  out  1  head sample is the final beat of a burst
- beat_cnt  out  16  beats accepted in the current burst, 0..BURST-1
- err  out  1  sticky: fifo_valid arrived with no pop outstanding

## Operation
- State: 3-entry circular queue (wr_ptr, rd_ptr, occ 0..3), inflight bit (pop issued last cycle), beat counter, err flag.
- fifo_pop = !rst & !flush & !fifo_empty & (occ + inflight < 3). It is combinational from registered state plus fifo_empty. No path from out_ready to fifo_pop.
- inflight next = fifo_pop.
- On fifo_valid with inflight=1: write fifo_rdata at wr_ptr, wr_ptr advances mod 3.
- On fifo_valid with inflight=0: data dropped, err set. err clears only on rst.
- out_valid = (occ != 0). out_data = queue[rd_ptr], registered storage.
- On transfer: rd_ptr advances mod 3.
- Simultaneous write and transfer in one cycle: occ unchanged.
- Credit rule guarantees occ never exceeds 3. Overflow is impossible by construction. Write at occ=3 is a design error; assertion required.
- beat_cnt increments on each transfer and wraps to 0 on the transfer where beat_cnt == BURST-1.
- out_last = out_valid & (beat_cnt == BURST-1).
- Stall (out_valid & !out_ready): out_data, out_last, beat_cnt hold stable.
- flush cycle:
  - fifo_pop=0, fifo_flush=1.
  - Any fifo_valid in that cycle is discarded without setting err.
  - Next cycle: occ=0, ptrs=0, inflight=0, beat_cnt=0, out_valid=0. err unchanged.
  - A transfer coinciding with flush is still counted by downstream but not by beat_cnt.
- rst: same clearing as flush plus err=0. Any in-flight data is discarded. fifo_valid in the first cycle after rst deassertion is ignored without setting err.

## Timing
- Reset values: fifo_pop=0, fifo_flush=0 (follows flush), out_data=0, out_valid=0, out_last=0, beat_cnt=0, err=0.
- Latency pop→out_valid: pop at cycle t, fifo_valid at t+1, out_valid at t+2.
- Latency rst-deassert→first pop: same cycle, if fifo_empty=0.
- Throughput: 1 sample/cycle sustained with out_ready=1 and FIFO non-empty.
  - Steady state: occ=1, inflight=1.
- Backpressure: with out_ready=0, at most 3 pops are issued, then fifo_pop stays 0.
  - Pops resume the cycle after the first transfer frees a credit.
- fifo_empty rising: pops stop the same cycle. Buffered data continues draining.

## Test plan
- Reset then stream: FIFO holds 0x0001..0x0010, BURST=8, out_ready=1.
  - Expect out_data 1..16 on consecutive cycles starting 2 cycles after the first pop.
  - out_last high on values 8 and 16.
  - beat_cnt wraps 7→0.
- Backpressure: out_ready=0 for 10 cycles with FIFO full.
  - Expect exactly 3 pops, occ=3, out_data stable at first sample.
  - On release, 1 sample/cycle with no gap or loss.
- Random out_ready (50%) over 1000 samples.
  - Expect an output sequence identical to the input.
  - out_last on every 8th beat, occ ≤ 3, err=0.
- Flush mid-burst after 5 beats, with a pop in flight:
  - fifo_flush=1 that cycle, returned data discarded.
  - Next cycle out_valid=0, beat_cnt=0.
  - Refilled data restarts burst framing at beat 0.
- Spurious fifo_valid with no prior pop:
  - err=1 from the next cycle and stays 1 through flush.
  - err clears only on rst.
- fifo_empty toggling each cycle:
  - Pops only when fifo_empty=0.
  - Output order preserved, no duplicate samples.
